// File: rtl/cbfp_pkg.sv
// cbfp_pkg: shared constants, vector typedefs and the shift helper for the CBFP denorm path.
package cbfp_pkg;

   localparam int unsigned CBFP_IDX_WIDTH  = 5;
   localparam int unsigned CBFP_MAX_IDX    = 12;
   localparam int unsigned CBFP_I_WIDTH    = 11;
   localparam int unsigned CBFP_DATA_WIDTH = 16;
   localparam int unsigned CBFP_N_POINT    = 512;

   typedef logic [CBFP_DATA_WIDTH-1:0][CBFP_IDX_WIDTH-1:0]      idx_vec_t;
   typedef logic signed [CBFP_DATA_WIDTH-1:0][CBFP_I_WIDTH-1:0] mant_vec_t;

   // Left shift that brings a lane at exponent index idx back to the max_idx scale.
   // Indices above max_idx carry no extra information and clamp to no shift.
   function automatic int unsigned shift_amt(input int unsigned idx, input int unsigned max_idx);
      return (idx > max_idx) ? 0 : (max_idx - idx);
   endfunction

endpackage

// File: rtl/cbfp_idx_fifo.sv
// cbfp_idx_fifo: circular buffer of index vectors, pointers carry one extra wrap bit.
// Push/pop qualification (full/empty guarding) is done by the caller.
module cbfp_idx_fifo
   import cbfp_pkg::*;
#(
   parameter int unsigned WIDTH = $bits(idx_vec_t),
   parameter int unsigned DEPTH = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push,
   input  logic                    pop,
   input  logic [WIDTH-1:0]        wdata,
   output logic [WIDTH-1:0]        rdata,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  level
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wptr_q;
   logic [AW:0]      rptr_q;

   // Pointer advance; reset empties the buffer.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (push) wptr_q <= wptr_q + 1'b1;
         if (pop)  rptr_q <= rptr_q + 1'b1;
      end
   end

   // Storage is not reset: a slot is only read after it has been written.
   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q[AW-1:0]] <= wdata;
   end

   assign rdata = mem_q[rptr_q[AW-1:0]];
   assign empty = (wptr_q == rptr_q);
   assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign level = wptr_q - rptr_q;

endmodule

// File: rtl/cbfp_denorm.sv
// cbfp_denorm: realigns buffered exponent indices with later mantissa vectors, shifts each
// lane back to the common MAX_IDX scale and tags frame ends. One cycle latency.
// Optional build macro CBFP_DENORM_STAT_EN enables sticky err_ovf/err_unf and fifo_level;
// without it those outputs are tied to 0.
module cbfp_denorm
   import cbfp_pkg::*;
#(
   parameter int unsigned I_WIDTH    = CBFP_I_WIDTH,
   parameter int unsigned IDX_WIDTH  = CBFP_IDX_WIDTH,
   parameter int unsigned MAX_IDX    = CBFP_MAX_IDX,
   parameter int unsigned O_WIDTH    = I_WIDTH + MAX_IDX,
   parameter int unsigned DATA_WIDTH = CBFP_DATA_WIDTH,
   parameter int unsigned DEPTH      = 8,
   parameter int unsigned N_POINT    = CBFP_N_POINT
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 idx_valid,
   input  logic [IDX_WIDTH*DATA_WIDTH-1:0]      idx_in,
   input  logic                                 din_valid,
   input  logic signed [I_WIDTH*DATA_WIDTH-1:0] din_re,
   input  logic signed [I_WIDTH*DATA_WIDTH-1:0] din_im,
   output logic                                 dout_valid,
   output logic signed [O_WIDTH*DATA_WIDTH-1:0] dout_re,
   output logic signed [O_WIDTH*DATA_WIDTH-1:0] dout_im,
   output logic                                 frame_last,
   output logic                                 err_ovf,
   output logic                                 err_unf,
   output logic [$clog2(DEPTH):0]               fifo_level
);

   localparam int unsigned IW         = IDX_WIDTH * DATA_WIDTH;
   localparam int unsigned OW         = O_WIDTH * DATA_WIDTH;
   localparam int unsigned FRAME_VECS = N_POINT / DATA_WIDTH;
   localparam int unsigned CW         = (FRAME_VECS > 1) ? $clog2(FRAME_VECS) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_VECS - 1);

   logic                   fifo_full, fifo_empty;
   logic                   push, pop, bypass, underflow;
   logic [IW-1:0]          fifo_rdata, idx_sel;
   logic [$clog2(DEPTH):0] fifo_lvl;
   logic signed [OW-1:0]   shf_re, shf_im;

   logic                   dout_valid_q, frame_last_q;
   logic signed [OW-1:0]   dout_re_q, dout_im_q;
   logic [CW-1:0]          cnt_q;

   // Bypass leaves the FIFO untouched; a push into a full FIFO is allowed only alongside a pop.
   assign bypass    = fifo_empty & idx_valid & din_valid;
   assign pop       = din_valid & ~fifo_empty;
   assign push      = idx_valid & ~bypass & (~fifo_full | pop);
   assign underflow = din_valid & fifo_empty & ~idx_valid;

   cbfp_idx_fifo #(
      .WIDTH (IW),
      .DEPTH (DEPTH)
   ) u_idx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .wdata (idx_in),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_lvl)
   );

   // Index source: live input on bypass, MAX_IDX (no shift) on underflow, else FIFO head.
   always_comb begin
      idx_sel = fifo_rdata;
      if (bypass) begin
         idx_sel = idx_in;
      end else if (underflow) begin
         idx_sel = {DATA_WIDTH{IDX_WIDTH'(MAX_IDX)}};
      end
   end

   // Per-lane sign extension and exact left shift back to the common scale.
   always_comb begin
      int unsigned sh;
      sh     = 0;
      shf_re = '0;
      shf_im = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         sh = shift_amt(32'(idx_sel[i*IDX_WIDTH +: IDX_WIDTH]), MAX_IDX);
         shf_re[i*O_WIDTH +: O_WIDTH] = O_WIDTH'($signed(din_re[i*I_WIDTH +: I_WIDTH])) <<< sh;
         shf_im[i*O_WIDTH +: O_WIDTH] = O_WIDTH'($signed(din_im[i*I_WIDTH +: I_WIDTH])) <<< sh;
      end
   end

   // Output registers and frame counter; data holds between valid vectors.
   always_ff @(posedge clk) begin
      if (rst) begin
         dout_valid_q <= 1'b0;
         frame_last_q <= 1'b0;
         dout_re_q    <= '0;
         dout_im_q    <= '0;
         cnt_q        <= '0;
      end else begin
         dout_valid_q <= din_valid;
         frame_last_q <= din_valid && (cnt_q == CNT_LAST);
         if (din_valid) begin
            dout_re_q <= shf_re;
            dout_im_q <= shf_im;
            cnt_q     <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
         end
      end
   end

   assign dout_valid = dout_valid_q;
   assign frame_last = frame_last_q;
   assign dout_re    = dout_re_q;
   assign dout_im    = dout_im_q;

`ifdef CBFP_DENORM_STAT_EN
   logic overflow;
   logic err_ovf_q, err_unf_q;

   assign overflow = idx_valid & fifo_full & ~pop;

   // Sticky error flags, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_ovf_q <= 1'b0;
         err_unf_q <= 1'b0;
      end else begin
         if (overflow)  err_ovf_q <= 1'b1;
         if (underflow) err_unf_q <= 1'b1;
      end
   end

   assign err_ovf    = err_ovf_q;
   assign err_unf    = err_unf_q;
   assign fifo_level = fifo_lvl;
`else
   logic unused_lvl;
   assign unused_lvl = ^fifo_lvl;
   assign err_ovf    = 1'b0;
   assign err_unf    = 1'b0;
   assign fifo_level = '0;
`endif

endmodule

// File: tb/tb_cbfp_denorm.sv
// tb_cbfp_denorm: directed table, multi-cycle sequences and random stimulus against a
// queue-based reference model.
module tb_cbfp_denorm;
   import cbfp_pkg::*;

   localparam int unsigned IW    = 11;
   localparam int unsigned XW    = 5;
   localparam int unsigned MAXI  = 12;
   localparam int unsigned OW    = 23;
   localparam int unsigned DW    = 16;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned NPT   = 512;
   localparam int unsigned FV    = NPT / DW;
`ifdef CBFP_DENORM_STAT_EN
   localparam bit STAT = 1'b1;
`else
   localparam bit STAT = 1'b0;
`endif

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     idx_valid, din_valid;
   logic [XW*DW-1:0]         idx_in;
   logic signed [IW*DW-1:0]  din_re, din_im;
   logic                     dout_valid, frame_last, err_ovf, err_unf;
   logic signed [OW*DW-1:0]  dout_re, dout_im;
   logic [$clog2(DEPTH):0]   fifo_level;

   cbfp_denorm #(
      .I_WIDTH    (IW),
      .IDX_WIDTH  (XW),
      .MAX_IDX    (MAXI),
      .O_WIDTH    (OW),
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH),
      .N_POINT    (NPT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .idx_valid  (idx_valid),
      .idx_in     (idx_in),
      .din_valid  (din_valid),
      .din_re     (din_re),
      .din_im     (din_im),
      .dout_valid (dout_valid),
      .dout_re    (dout_re),
      .dout_im    (dout_im),
      .frame_last (frame_last),
      .err_ovf    (err_ovf),
      .err_unf    (err_unf),
      .fifo_level (fifo_level)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model state.
   logic [XW*DW-1:0] mq[$];
   int m_cnt = 0;
   bit m_ovf = 0, m_unf = 0, e_valid = 0, e_last = 0;
   int e_re[DW], e_im[DW];

   function automatic void model_step();
      logic [XW*DW-1:0] iv;
      bit byp, use_max;
      int k, s;
      byp = 0; use_max = 0; iv = '0;
      if (rst) begin
         mq.delete();
         m_cnt = 0; m_ovf = 0; m_unf = 0; e_valid = 0; e_last = 0;
         for (int i = 0; i < DW; i++) begin e_re[i] = 0; e_im[i] = 0; end
         return;
      end
      e_valid = din_valid;
      e_last  = 0;
      if (din_valid) begin
         if (mq.size() > 0) iv = mq.pop_front();
         else if (idx_valid) begin iv = idx_in; byp = 1; end
         else begin use_max = 1; m_unf = 1; end
         for (int i = 0; i < DW; i++) begin
            k = use_max ? MAXI : int'(iv[i*XW +: XW]);
            s = (k > MAXI) ? 0 : (MAXI - k);
            e_re[i] = int'($signed(din_re[i*IW +: IW])) * (1 << s);
            e_im[i] = int'($signed(din_im[i*IW +: IW])) * (1 << s);
         end
         e_last = (m_cnt == FV - 1);
         m_cnt  = (m_cnt + 1) % FV;
      end
      if (idx_valid && !byp) begin
         if (mq.size() < DEPTH) mq.push_back(idx_in);
         else m_ovf = 1;
      end
   endfunction

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic cmp(input string name, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // Lane-by-lane data check against explicit per-lane expectations.
   task automatic cmp_data(input string name, input int xre[DW], input int xim[DW]);
      bit err;
      int gr, gi;
      err = 0;
      total++;
      for (int i = 0; i < DW; i++) begin
         gr = int'($signed(dout_re[i*OW +: OW]));
         gi = int'($signed(dout_im[i*OW +: OW]));
         if (!err && (gr != xre[i] || gi != xim[i])) begin
            $display("FAIL %s lane %0d: got re=%0d im=%0d expected re=%0d im=%0d",
                     name, i, gr, gi, xre[i], xim[i]);
            err = 1;
         end
      end
      if (err) bad++;
   endtask

   task automatic set_idx(input int v, input int v5);
      for (int i = 0; i < DW; i++) idx_in[i*XW +: XW] = XW'((i == 5) ? v5 : v);
   endtask

   task automatic set_din(input int re, input int re5, input int im);
      for (int i = 0; i < DW; i++) begin
         din_re[i*IW +: IW] = IW'((i == 5) ? re5 : re);
         din_im[i*IW +: IW] = IW'(im);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idx_valid = 1'b1; din_valid = 1'b1;
      set_idx(3, 3); set_din(5, 5, 5);
      tick();
      rst = 1'b0; idx_valid = 1'b0; din_valid = 1'b0;
   endtask

   task automatic check_model(input string tag);
      cmp({tag, " valid"}, int'(dout_valid), int'(e_valid));
      cmp({tag, " last"}, int'(frame_last), int'(e_last));
      cmp({tag, " ovf"}, int'(err_ovf), int'(STAT & m_ovf));
      cmp({tag, " unf"}, int'(err_unf), int'(STAT & m_unf));
      cmp({tag, " level"}, int'(fifo_level), STAT ? mq.size() : 0);
      if (e_valid) cmp_data({tag, " data"}, e_re, e_im);
   endtask

   typedef struct {
      bit iv; int idx; int idx5;
      bit dv; int re; int re5; int im;
      bit ev; int ere; int ere5; int eim; int eim5; int elvl; bit eunf;
   } vec_t;

   vec_t tbl[5];
   int   xre[DW], xim[DW];

   initial begin
      tbl[0] = '{1, 3, 3,   0, 0, 0, 0,         0, 0, 0, 0, 0, 1, 0};
      tbl[1] = '{0, 0, 0,   1, 1, 1, -1,        1, 512, 512, -512, -512, 0, 0};
      tbl[2] = '{1, 12, 12, 1, 100, 100, 100,   1, 100, 100, 100, 100, 0, 0};
      tbl[3] = '{1, 0, 20,  1, 1, -1024, 1,     1, 4096, -1024, 4096, 1, 0, 0};
      tbl[4] = '{0, 0, 0,   1, 7, 7, -7,        1, 7, 7, -7, -7, 0, 1};

      rst = 1'b0; idx_valid = 1'b0; din_valid = 1'b0; idx_in = '0; din_re = '0; din_im = '0;
      do_reset();
      cmp("reset valid", int'(dout_valid), 0);
      cmp("reset last", int'(frame_last), 0);
      cmp("reset ovf", int'(err_ovf), 0);
      cmp("reset unf", int'(err_unf), 0);
      cmp("reset level", int'(fifo_level), 0);
      cmp("reset data nonzero", int'((dout_re != '0) || (dout_im != '0)), 0);

      // Directed table.
      for (int t = 0; t < 5; t++) begin
         idx_valid = tbl[t].iv; din_valid = tbl[t].dv;
         set_idx(tbl[t].idx, tbl[t].idx5);
         set_din(tbl[t].re, tbl[t].re5, tbl[t].im);
         tick();
         cmp($sformatf("tbl%0d valid", t), int'(dout_valid), int'(tbl[t].ev));
         cmp($sformatf("tbl%0d level", t), int'(fifo_level), STAT ? tbl[t].elvl : 0);
         cmp($sformatf("tbl%0d unf", t), int'(err_unf), int'(STAT & tbl[t].eunf));
         cmp($sformatf("tbl%0d ovf", t), int'(err_ovf), 0);
         if (tbl[t].ev) begin
            for (int i = 0; i < DW; i++) begin
               xre[i] = (i == 5) ? tbl[t].ere5 : tbl[t].ere;
               xim[i] = (i == 5) ? tbl[t].eim5 : tbl[t].eim;
            end
            cmp_data($sformatf("tbl%0d data", t), xre, xim);
         end
      end
      // Underflow flag stays set while idle.
      idx_valid = 1'b0; din_valid = 1'b0;
      for (int n = 0; n < 3; n++) tick();
      cmp("unf sticky", int'(err_unf), int'(STAT));

      // Fill, pop+push while full, drop on overflow, then drain in order.
      do_reset();
      cmp("unf cleared", int'(err_unf), 0);
      for (int k = 0; k < 8; k++) begin
         idx_valid = 1'b1; set_idx(k, k); tick();
      end
      cmp("full level", int'(fifo_level), STAT ? 8 : 0);
      cmp("full no ovf", int'(err_ovf), 0);
      idx_valid = 1'b1; set_idx(8, 8); din_valid = 1'b1; set_din(1, 1, -1); tick();
      cmp("popush level", int'(fifo_level), STAT ? 8 : 0);
      cmp("popush no ovf", int'(err_ovf), 0);
      for (int i = 0; i < DW; i++) begin xre[i] = 4096; xim[i] = -4096; end
      cmp_data("popush data", xre, xim);
      din_valid = 1'b0; set_idx(9, 9); tick();
      cmp("ovf set", int'(err_ovf), int'(STAT));
      cmp("ovf level", int'(fifo_level), STAT ? 8 : 0);
      idx_valid = 1'b0; din_valid = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         for (int i = 0; i < DW; i++) begin xre[i] = 1 << (12 - k); xim[i] = -(1 << (12 - k)); end
         cmp_data($sformatf("drain%0d", k), xre, xim);
         cmp($sformatf("drain%0d level", k), int'(fifo_level), STAT ? 8 - k : 0);
      end
      din_valid = 1'b0;

      // Frame boundaries, reset mid-frame.
      do_reset();
      idx_valid = 1'b1; din_valid = 1'b1; set_idx(12, 12);
      for (int n = 1; n <= 64 + 9; n++) begin
         set_din(n % 1000, n % 1000, -(n % 1000)); tick();
         cmp($sformatf("frame v%0d last", n), int'(frame_last), int'(n == 32 || n == 64));
      end
      rst = 1'b1; tick(); rst = 1'b0;
      cmp("midrst valid", int'(dout_valid), 0);
      cmp("midrst last", int'(frame_last), 0);
      cmp("midrst data nonzero", int'((dout_re != '0) || (dout_im != '0)), 0);
      for (int n = 1; n <= 32; n++) begin
         set_din(n, n, n); tick();
         cmp($sformatf("after rst v%0d last", n), int'(frame_last), int'(n == 32));
      end

      // Random stimulus against the model, with varying push/pop bias.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         int piv, pdv;
         case ((c / 500) % 3)
            0: begin piv = 70; pdv = 30; end
            1: begin piv = 30; pdv = 70; end
            default: begin piv = 50; pdv = 50; end
         endcase
         rst       = ($urandom_range(0, 299) == 0);
         idx_valid = ($urandom_range(0, 99) < piv);
         din_valid = ($urandom_range(0, 99) < pdv);
         for (int i = 0; i < DW; i++) begin
            idx_in[i*XW +: XW] = XW'($urandom_range(0, ($urandom_range(0, 7) == 0) ? 31 : MAXI));
            din_re[i*IW +: IW] = IW'($urandom);
            din_im[i*IW +: IW] = IW'($urandom);
         end
         tick();
         check_model($sformatf("rnd%0d", c));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
